// File: rtl/led_display_sequencer_if.sv
// Switch/button inputs and LED display outputs of the LED display sequencer.
// The board side (switches, buttons, LED block) is the master.
interface led_display_sequencer_if;
    logic [3:0] gray_in;
    logic       mode_btn;
    logic       step_btn;
    logic [3:0] bin_out;
    logic       update;
    logic [1:0] mode;

    modport master (output gray_in, mode_btn, step_btn, input bin_out, update, mode);
    modport slave  (input gray_in, mode_btn, step_btn, output bin_out, update, mode);
endinterface

// File: rtl/led_display_sequencer.sv
// LED display sequencer: drives the 4-bit LED value from Gray-coded switches (LIVE),
// a self-advancing demo count (AUTO) or a manually stepped frozen count (HOLD).
//
// state | meaning
// LIVE  | bin_out follows decoded, synchronised gray_in
// AUTO  | count advances once every TICK_DIV cycles
// HOLD  | count frozen, each step press adds one (mod 16)
module led_display_sequencer #(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic                    clock,
    input logic                    reset_n,
    led_display_sequencer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] TICK_TC = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
    localparam int BTN_MODE = 0;
    localparam int BTN_STEP = 1;

    typedef enum logic [1:0] {
        LIVE = 2'b00,
        AUTO = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          run;
    logic [3:0]    gray_s1;
    logic [3:0]    gray_s2;
    logic [3:0]    gray_dec;
    logic [1:0]    btn_s1;
    logic [1:0]    btn_s2;
    logic [1:0]    btn_acc;
    logic [1:0]    btn_press;
    logic [DW-1:0] deb_cnt [2];
    logic [PW-1:0] prescale;
    logic [3:0]    count;
    logic [3:0]    bin_q;
    logic [3:0]    bin_next;
    logic          update_q;

    // Reset asserts asynchronously everywhere; release reaches the logic via run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gray_s1 <= '0;
            gray_s2 <= '0;
            btn_s1  <= '0;
            btn_s2  <= '0;
        end else begin
            gray_s1 <= bus.gray_in;
            gray_s2 <= gray_s1;
            btn_s1  <= {bus.step_btn, bus.mode_btn};
            btn_s2  <= btn_s1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_acc    <= '0;
            btn_press  <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else if (run) begin
            for (int i = 0; i < 2; i++) begin
                btn_press[i] <= 1'b0;
                if (btn_s2[i] == btn_acc[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_TC) begin
                    btn_acc[i]   <= btn_s2[i];
                    btn_press[i] <= btn_s2[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        gray_dec = {gray_s2[3], ^gray_s2[3:2], ^gray_s2[3:1], ^gray_s2[3:0]};
        bin_next = gray_dec;
        if (state == AUTO || state == HOLD) begin
            bin_next = count;
        end
    end

    // A mode press always takes priority over a step press or a prescaler terminal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LIVE;
            count    <= '0;
            prescale <= '0;
            bin_q    <= '0;
            update_q <= 1'b0;
        end else if (run) begin
            bin_q    <= bin_next;
            update_q <= (bin_next != bin_q);
            case (state)
                LIVE: begin
                    if (btn_press[BTN_MODE]) begin
                        state    <= AUTO;
                        count    <= bin_q;
                        prescale <= '0;
                    end
                end
                AUTO: begin
                    if (btn_press[BTN_MODE]) begin
                        state <= HOLD;
                    end else if (prescale == TICK_TC) begin
                        count    <= count + 4'd1;
                        prescale <= '0;
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                HOLD: begin
                    if (btn_press[BTN_MODE]) begin
                        state <= LIVE;
                    end else if (btn_press[BTN_STEP]) begin
                        count <= count + 4'd1;
                    end
                end
                default: state <= LIVE;
            endcase
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.update  = update_q;
    assign bus.mode    = state;
endmodule

// File: tb/tb_led_display_sequencer.sv
// Self-checking bench for led_display_sequencer: directed steps plus random
// switch/button activity, compared every cycle against a behavioural model.
module tb_led_display_sequencer;
    localparam int TD = 4;
    localparam int DB = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    led_display_sequencer_if bus ();

    led_display_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 LIVE, 1 AUTO, 2 HOLD; button index 0 mode, 1 step.
    int m_mode, m_cnt, m_pre, m_bin, m_upd, m_rel, m_g1, m_g2;
    int b_s1[2], b_s2[2], b_acc[2], b_run[2], b_ev[2];

    function automatic int g2b(input int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pre = 0; m_bin = 0; m_upd = 0;
        m_rel = 0; m_g1 = 0; m_g2 = 0;
        for (int i = 0; i < 2; i++) begin
            b_s1[i] = 0; b_s2[i] = 0; b_acc[i] = 0; b_run[i] = 0; b_ev[i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        int nb;
        int btn[2];
        btn[0] = int'(bus.mode_btn);
        btn[1] = int'(bus.step_btn);
        if (!reset_n) return;
        if (m_rel >= 2) begin
            nb = (m_mode == 0) ? g2b(m_g2) : m_cnt;
            if (m_mode == 0) begin
                if (b_ev[0] != 0) begin m_mode = 1; m_cnt = m_bin; m_pre = 0; end
            end else if (m_mode == 1) begin
                if (b_ev[0] != 0) m_mode = 2;
                else if (m_pre == TD - 1) begin m_cnt = (m_cnt + 1) % 16; m_pre = 0; end
                else m_pre++;
            end else begin
                if (b_ev[0] != 0) m_mode = 0;
                else if (b_ev[1] != 0) m_cnt = (m_cnt + 1) % 16;
            end
            m_upd = (nb != m_bin) ? 1 : 0;
            m_bin = nb;
            for (int i = 0; i < 2; i++) begin
                b_ev[i] = 0;
                if (b_s2[i] == b_acc[i]) b_run[i] = 0;
                else begin
                    b_run[i]++;
                    if (b_run[i] == DB) begin
                        b_acc[i] = b_s2[i]; b_ev[i] = b_s2[i]; b_run[i] = 0;
                    end
                end
            end
        end
        m_g2 = m_g1;
        m_g1 = int'(bus.gray_in);
        for (int i = 0; i < 2; i++) begin
            b_s2[i] = b_s1[i];
            b_s1[i] = btn[i];
        end
        m_rel++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("bin_out", bus.bin_out, m_bin);
        check("update", bus.update, m_upd);
        check("mode", bus.mode, m_mode);
    endtask

    // which: bit0 mode button, bit1 step button
    task automatic press(input int which, input int hold, input int after);
        if (which & 1) bus.mode_btn = 1'b1;
        if (which & 2) bus.step_btn = 1'b1;
        repeat (hold) tick();
        bus.mode_btn = 1'b0;
        bus.step_btn = 1'b0;
        repeat (after) tick();
    endtask

    initial begin
        int codes[16];
        int t15, t0, n, v, j, tmp, found;

        bus.gray_in  = 4'd0;
        bus.mode_btn = 1'b0;
        bus.step_btn = 1'b0;
        model_reset();
        #1;
        check("reset_bin", bus.bin_out, 0);
        check("reset_update", bus.update, 0);
        check("reset_mode", bus.mode, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // LIVE sweep over all Gray codes in random order
        for (int i = 0; i < 16; i++) codes[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = codes[i]; codes[i] = codes[j]; codes[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            bus.gray_in = 4'(codes[i]);
            repeat (4) tick();
        end
        bus.gray_in = 4'b0110;
        repeat (4) tick();
        check("gray_0110", bus.bin_out, 4'b0100);
        bus.gray_in = 4'b1000;
        repeat (2) tick();
        check("gray_1000_edge2", bus.bin_out, 4'b0100);
        tick();
        check("gray_1000_edge3", bus.bin_out, 4'b1111);
        check("gray_1000_pulse", bus.update, 1);
        tick();
        check("gray_1000_pulse_end", bus.update, 0);
        repeat (4) tick();

        // Debounce: short glitch rejected, long press accepted after 2+3+1 edges
        bus.gray_in = 4'b1001;
        repeat (4) tick();
        check("preload_14", bus.bin_out, 14);
        press(1, 2, 8);
        check("glitch_ignored", bus.mode, 0);
        bus.mode_btn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) check("deb_edge5", bus.mode, 0);
        end
        check("deb_edge6", bus.mode, 1);
        bus.mode_btn = 1'b0;

        // AUTO wrap 14 -> 15 -> 0 with switches ignored
        t15 = -1; t0 = -1; n = 0;
        while (t0 < 0 && n < 40) begin
            bus.gray_in = 4'($urandom_range(15, 0));
            tick();
            if (bus.update === 1'b1 && bus.bin_out === 4'd15 && t15 < 0) t15 = n;
            if (bus.update === 1'b1 && bus.bin_out === 4'd0 && t15 >= 0) t0 = n;
            n++;
        end
        check("auto_reach_0", (t0 >= 0) ? 1 : 0, 1);
        check("auto_period", t0 - t15, TD);
        check("auto_mode", bus.mode, 1);

        // HOLD at 15: time the press so the count is 15 when it lands
        n = 0;
        while (!(m_mode == 1 && m_cnt == 14 && m_pre <= 1) && n < 100) begin tick(); n++; end
        press(1, 4, 2);
        check("hold_mode", bus.mode, 2);
        check("hold_val15", bus.bin_out, 15);
        repeat (20) tick();
        check("hold_stays15", bus.bin_out, 15);
        press(2, 4, 3);
        check("step_wrap_0", bus.bin_out, 0);
        press(2, 4, 3);
        check("step_to_1", bus.bin_out, 1);
        repeat (4) press(2, 4, 3);
        check("step_to_5", bus.bin_out, 5);

        // mode+step together in HOLD: mode wins
        press(3, 4, 2);
        check("collide_hold_mode", bus.mode, 0);
        check("collide_hold_val", bus.bin_out, 5);
        bus.gray_in = 4'b0011;
        repeat (4) tick();
        v = int'(bus.bin_out);
        press(2, 4, 4);
        check("step_in_live_val", bus.bin_out, v);
        check("step_in_live_mode", bus.mode, 0);

        // mode press landing on the prescaler terminal: no increment
        press(1, 4, 2);
        check("auto_again", bus.mode, 1);
        n = 0;
        while (m_pre != 2 && n < 10) begin tick(); n++; end
        press(1, 4, 2);
        v = int'(bus.bin_out);
        check("collide_tc_mode", bus.mode, 2);
        repeat (3) tick();
        check("collide_tc_val", bus.bin_out, v);

        // Random switches and bouncy buttons
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3, 0) == 0) bus.gray_in = 4'($urandom_range(15, 0));
            if ($urandom_range(5, 0) == 0) bus.mode_btn = ~bus.mode_btn;
            if ($urandom_range(3, 0) == 0) bus.step_btn = ~bus.step_btn;
            tick();
        end
        bus.mode_btn = 1'b0;
        bus.step_btn = 1'b0;
        repeat (8) tick();

        // Reset in AUTO at value 9
        for (int k = 0; k < 3; k++) if (m_mode != 1) press(1, 4, 2);
        check("enter_auto_for_reset", bus.mode, 1);
        n = 0; found = 0;
        while (found == 0 && n < 100) begin
            tick();
            if (bus.bin_out === 4'd9 && bus.mode === 2'b01) found = 1;
            n++;
        end
        check("reach_9", found, 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_bin", bus.bin_out, 0);
        check("async_rst_mode", bus.mode, 0);
        check("async_rst_update", bus.update, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("post_reset_live", bus.mode, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
